word_gen_v3: RTL and testbench



---
 rtl/word_gen_v3_pkg.sv | 29 ++
 rtl/word_gen_range_cnt.sv | 73 +++++++
 rtl/word_gen_v3.sv | 245 ++++++++++++++++++++++++
 tb/tb_word_gen_v3.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_gen_v3_pkg.sv
// Shared state encodings and constants for the word_gen_v3 generator and its range counters.
package word_gen_v3_pkg;

   localparam logic [7:0] MAGIC   = 8'hBB;
   localparam int         CFG_MSB = 7;

   localparam logic [3:0] C_NUM_RANGES  = 4'd0;
   localparam logic [3:0] C_R_NUM_CHARS = 4'd1;
   localparam logic [3:0] C_R_START     = 4'd2;
   localparam logic [3:0] C_R_POS       = 4'd3;
   localparam logic [3:0] C_R_CHARS     = 4'd4;
   localparam logic [3:0] C_GEN0        = 4'd5;
   localparam logic [3:0] C_GEN1        = 4'd6;
   localparam logic [3:0] C_GEN2        = 4'd7;
   localparam logic [3:0] C_GEN3        = 4'd8;
   localparam logic [3:0] C_MAGIC       = 4'd9;
   localparam logic [3:0] C_DONE        = 4'd10;
   localparam logic [3:0] C_ERROR       = 4'd11;

   localparam logic [1:0] G_IDLE  = 2'd0;
   localparam logic [1:0] G_READY = 2'd1;
   localparam logic [1:0] G_LOAD  = 2'd2;
   localparam logic [1:0] G_GEN   = 2'd3;

   function automatic int chars_max(input int char_bits);
      return (1 << char_bits) - 1;
   endfunction

endpackage

// File: rtl/word_gen_range_cnt.sv
// One substitution range: character store, its configuration registers and an
// odometer digit that advances on carry_i and reports wrap through carry_o.
module word_gen_range_cnt
   import word_gen_v3_pkg::*;
#(
   parameter int CHAR_BITS = 8,
   parameter int CHARS_MAX = chars_max(CHAR_BITS)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 sel_i,
   input  logic                 wr_nc_i,
   input  logic                 wr_start_i,
   input  logic                 wr_pos_i,
   input  logic                 wr_char_i,
   input  logic [CFG_MSB:0]     din_i,
   input  logic [CFG_MSB:0]     wr_addr_i,
   input  logic                 active_i,
   input  logic                 load_i,
   input  logic                 carry_i,
   output logic [CHAR_BITS-1:0] char_o,
   output logic [CFG_MSB:0]     pos_o,
   output logic                 last_o,
   output logic                 carry_o
);

   logic [CHAR_BITS-1:0] mem_q [CHARS_MAX];
   logic [CFG_MSB:0]     nc_q, nc_d, start_q, start_d, pos_q, pos_d, idx_q, idx_d;
   logic                 at_last_s;

   assign at_last_s = (idx_q == nc_q - 8'd1);

   always_comb begin
      nc_d    = nc_q;
      start_d = start_q;
      pos_d   = pos_q;
      idx_d   = idx_q;
      if (sel_i && wr_nc_i) nc_d = din_i;
      else                  nc_d = nc_q;
      if (sel_i && wr_start_i) start_d = din_i;
      else                     start_d = start_q;
      if (sel_i && wr_pos_i) pos_d = din_i;
      else                   pos_d = pos_q;
      if (load_i)                     idx_d = start_q;
      else if (active_i && carry_i)   idx_d = at_last_s ? 8'd0 : idx_q + 8'd1;
      else                            idx_d = idx_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         nc_q    <= 8'd0;
         start_q <= 8'd0;
         pos_q   <= 8'd0;
         idx_q   <= 8'd0;
      end else begin
         nc_q    <= nc_d;
         start_q <= start_d;
         pos_q   <= pos_d;
         idx_q   <= idx_d;
      end
   end

   // Unreset store so it maps onto distributed RAM.
   always_ff @(posedge CLK) begin
      if (sel_i && wr_char_i) mem_q[wr_addr_i] <= din_i[CHAR_BITS-1:0];
   end

   assign char_o  = mem_q[idx_q];
   assign pos_o   = pos_q;
   assign last_o  = active_i ? at_last_s : 1'b1;
   assign carry_o = active_i ? (carry_i & at_last_s) : carry_i;

endmodule

// File: rtl/word_gen_v3.sv
// Word generator top: byte-stream configuration FSM, generation FSM,
// character insertion mux and the registered count-limit logic.
module word_gen_v3
   import word_gen_v3_pkg::*;
#(
   parameter int CHAR_BITS    = 8,
   parameter int RANGES_MAX   = 4,
   parameter int WORD_MAX_LEN = 8,
   parameter int CHARS_MAX    = chars_max(CHAR_BITS)
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic [7:0]                        din,
   input  logic                              wr_conf_en,
   output logic                              conf_full,
   input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] word_in,
   input  logic [15:0]                       word_id,
   input  logic                              word_list_end,
   input  logic                              word_wr_en,
   output logic                              word_full,
   input  logic                              rd_en,
   output logic                              empty,
   output logic [WORD_MAX_LEN*CHAR_BITS-1:0] dout,
   output logic [15:0]                       word_id_out,
   output logic [31:0]                       gen_id,
   output logic                              gen_end,
   output logic                              err_conf
);

   localparam int WW = WORD_MAX_LEN * CHAR_BITS;

   logic [3:0]       cst_q, cst_d;
   logic [CFG_MSB:0] nr_q, nr_d, rsel_q, rsel_d, cur_nc_q, cur_nc_d, ccnt_q, ccnt_d;
   logic [31:0]      num_gen_q, num_gen_d;
   logic [1:0]       gst_q, gst_d;
   logic             word_full_q, word_full_d, lend_q, lend_d, lim_last_q, lim_last_d;
   logic [WW-1:0]    word_q, word_d, dout_s;
   logic [15:0]      id_q, id_d;
   logic [31:0]      gen_id_q, gen_id_d;

   logic conf_full_s, cfg_acc_s, done_enter_s, accept_s, rd_eff_s, fin_s, restart_s;
   logic wr_nc_s, wr_start_s, wr_pos_s, wr_char_s, load_s;
   logic [RANGES_MAX-1:0] ract_s, rsel_s, rlast_s, car_in_s, car_out_s;
   logic [CHAR_BITS-1:0]  rch_s  [RANGES_MAX];
   logic [CFG_MSB:0]      rpos_s [RANGES_MAX];

   assign conf_full_s = (cst_q == C_DONE) || (cst_q == C_ERROR);
   assign cfg_acc_s   = wr_conf_en && !conf_full_s;
   assign accept_s    = word_wr_en && !word_full_q;
   assign rd_eff_s    = rd_en && (gst_q == G_GEN);
   // Range 0 carrying out means every active range sat on its last character.
   assign fin_s       = car_out_s[0] || (rd_eff_s && lim_last_q);
   assign restart_s   = fin_s && lend_q;
   assign load_s      = (gst_q == G_LOAD);
   assign wr_nc_s     = cfg_acc_s && (cst_q == C_R_NUM_CHARS);
   assign wr_start_s  = cfg_acc_s && (cst_q == C_R_START);
   assign wr_pos_s    = cfg_acc_s && (cst_q == C_R_POS);
   assign wr_char_s   = cfg_acc_s && (cst_q == C_R_CHARS);

   for (genvar r = 0; r < RANGES_MAX; r++) begin : g_rng
      if (r == RANGES_MAX - 1) begin : g_fast
         assign car_in_s[r] = rd_eff_s;
      end else begin : g_slow
         assign car_in_s[r] = car_out_s[r+1];
      end
      assign ract_s[r] = (nr_q > 8'(r));
      assign rsel_s[r] = (rsel_q == 8'(r));
      word_gen_range_cnt #(.CHAR_BITS(CHAR_BITS), .CHARS_MAX(CHARS_MAX)) u_cnt (
         .CLK       (CLK),
         .RST       (RST),
         .sel_i     (rsel_s[r]),
         .wr_nc_i   (wr_nc_s),
         .wr_start_i(wr_start_s),
         .wr_pos_i  (wr_pos_s),
         .wr_char_i (wr_char_s),
         .din_i     (din),
         .wr_addr_i (ccnt_q),
         .active_i  (ract_s[r]),
         .load_i    (load_s),
         .carry_i   (car_in_s[r]),
         .char_o    (rch_s[r]),
         .pos_o     (rpos_s[r]),
         .last_o    (rlast_s[r]),
         .carry_o   (car_out_s[r])
      );
   end

   always_comb begin
      cst_d        = cst_q;
      nr_d         = nr_q;
      rsel_d       = rsel_q;
      cur_nc_d     = cur_nc_q;
      ccnt_d       = ccnt_q;
      num_gen_d    = num_gen_q;
      done_enter_s = 1'b0;
      if (cfg_acc_s) begin
         case (cst_q)
            C_NUM_RANGES: begin
               nr_d   = din;
               rsel_d = 8'd0;
               if (din > 8'(RANGES_MAX)) cst_d = C_ERROR;
               else if (din == 8'd0)     cst_d = C_GEN0;
               else                      cst_d = C_R_NUM_CHARS;
            end
            C_R_NUM_CHARS: begin
               cur_nc_d = din;
               if (din == 8'd0 || {1'b0, din} > 9'(CHARS_MAX)) cst_d = C_ERROR;
               else                                             cst_d = C_R_START;
            end
            C_R_START: begin
               if (din >= cur_nc_q) cst_d = C_ERROR;
               else                 cst_d = C_R_POS;
            end
            C_R_POS: begin
               ccnt_d = 8'd0;
               if (din >= 8'(WORD_MAX_LEN)) cst_d = C_ERROR;
               else                         cst_d = C_R_CHARS;
            end
            C_R_CHARS: begin
               if (ccnt_q == cur_nc_q - 8'd1) begin
                  ccnt_d = 8'd0;
                  if (rsel_q == nr_q - 8'd1) begin
                     cst_d = C_GEN0;
                  end else begin
                     rsel_d = rsel_q + 8'd1;
                     cst_d  = C_R_NUM_CHARS;
                  end
               end else begin
                  ccnt_d = ccnt_q + 8'd1;
               end
            end
            C_GEN0: begin num_gen_d[7:0]   = din; cst_d = C_GEN1;  end
            C_GEN1: begin num_gen_d[15:8]  = din; cst_d = C_GEN2;  end
            C_GEN2: begin num_gen_d[23:16] = din; cst_d = C_GEN3;  end
            C_GEN3: begin num_gen_d[31:24] = din; cst_d = C_MAGIC; end
            C_MAGIC: begin
               if (din == MAGIC) begin
                  cst_d        = C_DONE;
                  done_enter_s = 1'b1;
               end else begin
                  cst_d = C_ERROR;
               end
            end
            default: cst_d = cst_q;
         endcase
      end else if (restart_s && cst_q == C_DONE) begin
         cst_d = C_NUM_RANGES;
      end else begin
         cst_d = cst_q;
      end
   end

   always_comb begin
      gst_d       = gst_q;
      word_full_d = word_full_q;
      word_d      = word_q;
      id_d        = id_q;
      lend_d      = lend_q;
      gen_id_d    = gen_id_q;
      lim_last_d  = lim_last_q;
      if (accept_s) begin
         word_full_d = 1'b1;
         word_d      = word_in;
         id_d        = word_id;
         lend_d      = word_list_end;
      end else if (fin_s) begin
         word_full_d = 1'b0;
      end else begin
         word_full_d = word_full_q;
      end
      case (gst_q)
         G_IDLE:  gst_d = done_enter_s ? G_READY : G_IDLE;
         G_READY: gst_d = (word_full_q || accept_s) ? G_LOAD : G_READY;
         G_LOAD: begin
            gst_d      = G_GEN;
            gen_id_d   = 32'd0;
            lim_last_d = (num_gen_q == 32'd1);
         end
         G_GEN: begin
            if (fin_s) begin
               gst_d = lend_q ? G_IDLE : G_READY;
            end else if (rd_eff_s) begin
               gen_id_d   = gen_id_q + 32'd1;
               // Precompute "next read is the limit" so the read path sees one flop.
               lim_last_d = (num_gen_q != 32'd0) && (gen_id_q + 32'd2 == num_gen_q);
            end else begin
               gst_d = gst_q;
            end
         end
         default: gst_d = G_IDLE;
      endcase
   end

   always_comb begin
      dout_s = word_q;
      for (int r = 0; r < RANGES_MAX; r++) begin
         for (int p = 0; p < WORD_MAX_LEN; p++) begin
            dout_s[p*CHAR_BITS +: CHAR_BITS] = (ract_s[r] && rpos_s[r] == 8'(p)) ?
               rch_s[r] : dout_s[p*CHAR_BITS +: CHAR_BITS];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cst_q       <= C_NUM_RANGES;
         nr_q        <= 8'd0;
         rsel_q      <= 8'd0;
         cur_nc_q    <= 8'd0;
         ccnt_q      <= 8'd0;
         num_gen_q   <= 32'd0;
         gst_q       <= G_IDLE;
         word_full_q <= 1'b0;
         word_q      <= {WW{1'b0}};
         id_q        <= 16'd0;
         lend_q      <= 1'b0;
         gen_id_q    <= 32'd0;
         lim_last_q  <= 1'b0;
      end else begin
         cst_q       <= cst_d;
         nr_q        <= nr_d;
         rsel_q      <= rsel_d;
         cur_nc_q    <= cur_nc_d;
         ccnt_q      <= ccnt_d;
         num_gen_q   <= num_gen_d;
         gst_q       <= gst_d;
         word_full_q <= word_full_d;
         word_q      <= word_d;
         id_q        <= id_d;
         lend_q      <= lend_d;
         gen_id_q    <= gen_id_d;
         lim_last_q  <= lim_last_d;
      end
   end

   assign conf_full   = conf_full_s;
   assign err_conf    = (cst_q == C_ERROR);
   assign word_full   = word_full_q;
   assign empty       = (gst_q != G_GEN);
   assign dout        = dout_s;
   assign word_id_out = id_q;
   assign gen_id      = gen_id_q;
   assign gen_end     = (gst_q == G_GEN) && ((&rlast_s) || lim_last_q) && lend_q;

endmodule

// File: tb/tb_word_gen_v3.sv
// Self-checking bench for word_gen_v3: randomized words and read pacing checked
// against a mixed-radix enumeration model of the expected output sequence.
module tb_word_gen_v3;

   localparam int RM = 4;
   localparam int WW = 64;

   logic          CLK = 1'b0, RST = 1'b1;
   logic [7:0]    din = 8'd0;
   logic          wr_conf_en = 1'b0, conf_full;
   logic [WW-1:0] word_in = '0;
   logic [15:0]   word_id = 16'd0;
   logic          word_list_end = 1'b0, word_wr_en = 1'b0, word_full;
   logic          rd_en = 1'b0, empty;
   logic [WW-1:0] dout;
   logic [15:0]   word_id_out;
   logic [31:0]   gen_id;
   logic          gen_end, err_conf;

   word_gen_v3 dut (
      .CLK(CLK), .RST(RST), .din(din), .wr_conf_en(wr_conf_en), .conf_full(conf_full),
      .word_in(word_in), .word_id(word_id), .word_list_end(word_list_end),
      .word_wr_en(word_wr_en), .word_full(word_full), .rd_en(rd_en), .empty(empty),
      .dout(dout), .word_id_out(word_id_out), .gen_id(gen_id), .gen_end(gen_end),
      .err_conf(err_conf)
   );

   always #5 CLK = ~CLK;

   int tests_run = 0, tests_failed = 0;

   int         nr, ngen;
   int         nc [RM];
   int         st [RM];
   int         ps [RM];
   logic [7:0] chs [RM][256];
   logic [7:0] cq [$];

   logic [WW-1:0] exp_d [$];
   int            exp_g [$];
   bit            exp_e [$];

   task automatic do_reset();
      #2 RST = 1'b1;
      rd_en = 1'b0; word_wr_en = 1'b0; wr_conf_en = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic send_bytes();
      for (int i = 0; i < cq.size(); i++) begin
         @(posedge CLK); #1 din = cq[i]; wr_conf_en = 1'b1;
      end
      @(posedge CLK); #1 wr_conf_en = 1'b0;
      cq.delete();
   endtask

   task automatic send_conf(input logic [7:0] magic);
      cq.delete();
      cq.push_back(8'(nr));
      for (int r = 0; r < nr; r++) begin
         cq.push_back(8'(nc[r])); cq.push_back(8'(st[r])); cq.push_back(8'(ps[r]));
         for (int c = 0; c < nc[r]; c++) cq.push_back(chs[r][c]);
      end
      for (int b = 0; b < 4; b++) cq.push_back(8'((ngen >> (8*b)) & 255));
      cq.push_back(magic);
      send_bytes();
   endtask

   // Enumerate combinations as a mixed-radix number, range 0 most significant.
   task automatic model_word(input logic [WW-1:0] w, input bit lend);
      int total, lin, cnt, rem;
      int d [RM];
      logic [WW-1:0] o;
      total = 1; lin = 0; cnt = 0;
      for (int r = 0; r < nr; r++) begin
         total = total * nc[r];
         lin   = lin * nc[r] + st[r];
      end
      for (int k = lin; k < total && (ngen == 0 || cnt < ngen); k++) begin
         rem = k;
         for (int r = nr - 1; r >= 0; r--) begin
            d[r] = rem % nc[r];
            rem  = rem / nc[r];
         end
         o = w;
         for (int r = 0; r < nr; r++) o[ps[r]*8 +: 8] = chs[r][d[r]];
         exp_d.push_back(o); exp_g.push_back(cnt); exp_e.push_back(1'b0);
         cnt++;
      end
      if (lend) exp_e[exp_e.size()-1] = 1'b1;
   endtask

   task automatic push_word(input logic [WW-1:0] w, input logic [15:0] id, input bit lend);
      int n = 0;
      while (word_full === 1'b1 && n < 200) begin @(negedge CLK); n++; end
      tests_run++;
      if (word_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL push_wait: word_full got %b want 0", word_full);
      end
      @(posedge CLK); #1 word_in = w; word_id = id; word_list_end = lend; word_wr_en = 1'b1;
      @(posedge CLK); #1 word_wr_en = 1'b0;
   endtask

   task automatic drain(input int pct, input logic [15:0] id, input string tag);
      int k = 0, cyc = 0, n;
      n = exp_d.size();
      while (k < n && cyc < 4000) begin
         @(posedge CLK); #1 rd_en = ($urandom_range(99) < pct);
         @(negedge CLK);
         if (!empty && rd_en) begin
            tests_run += 4;
            if (dout !== exp_d[k]) begin
               tests_failed++;
               $display("FAIL %s dout[%0d]: got %h want %h", tag, k, dout, exp_d[k]);
            end
            if (gen_id !== 32'(exp_g[k])) begin
               tests_failed++;
               $display("FAIL %s gen_id[%0d]: got %0d want %0d", tag, k, gen_id, exp_g[k]);
            end
            if (word_id_out !== id) begin
               tests_failed++;
               $display("FAIL %s word_id_out[%0d]: got %h want %h", tag, k, word_id_out, id);
            end
            if (gen_end !== exp_e[k]) begin
               tests_failed++;
               $display("FAIL %s gen_end[%0d]: got %b want %b", tag, k, gen_end, exp_e[k]);
            end
            k++;
         end
         cyc++;
      end
      tests_run++;
      if (k != n) begin
         tests_failed++;
         $display("FAIL %s timeout: got %0d outputs want %0d", tag, k, n);
      end
      @(posedge CLK); #1 rd_en = 1'b0;
      @(negedge CLK);
      tests_run++;
      if (empty !== 1'b1 || word_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s word_end: empty=%b word_full=%b want 1/0", tag, empty, word_full);
      end
      exp_d.delete(); exp_g.delete(); exp_e.delete();
   endtask

   task automatic set_two_ranges(input int s1, input int lim);
      nr = 2; ngen = lim;
      nc[0] = 2; st[0] = 0;  ps[0] = 0; chs[0][0] = "a"; chs[0][1] = "b";
      nc[1] = 3; st[1] = s1; ps[1] = 2; chs[1][0] = "x"; chs[1][1] = "y"; chs[1][2] = "z";
   endtask

   task automatic test_reset();
      RST = 1'b1;
      @(negedge CLK);
      tests_run++;
      if (empty !== 1'b1 || word_full !== 1'b0 || conf_full !== 1'b0 || err_conf !== 1'b0 ||
          gen_id !== 32'd0 || word_id_out !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset: empty=%b full=%b conf_full=%b err=%b gen_id=%0d id=%h want 1/0/0/0/0/0",
                  empty, word_full, conf_full, err_conf, gen_id, word_id_out);
      end
      do_reset();
   endtask

   task automatic test_pass_through();
      logic [WW-1:0] w;
      do_reset();
      nr = 0; ngen = 0;
      send_conf(8'hBB);
      for (int i = 0; i < 3; i++) begin
         w = {$urandom, $urandom};
         model_word(w, i == 2);
         push_word(w, 16'(16'h100 + i), i == 2);
         drain(100, 16'(16'h100 + i), "pass");
      end
      tests_run++;
      if (conf_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL pass_conf_full: got %b want 0", conf_full);
      end
   endtask

   task automatic test_two_ranges();
      do_reset();
      set_two_ranges(1, 0);
      send_conf(8'hBB);
      model_word({8{8'h2D}}, 1'b1);
      push_word({8{8'h2D}}, 16'h0202, 1'b1);
      drain(100, 16'h0202, "two_ranges");
   endtask

   task automatic test_limit();
      do_reset();
      set_two_ranges(0, 4);
      send_conf(8'hBB);
      for (int i = 0; i < 2; i++) begin
         model_word({8{8'h2D}}, i == 1);
         push_word({8{8'h2D}}, 16'(16'h0300 + i), i == 1);
         drain(100, 16'(16'h0300 + i), "limit");
      end
   endtask

   task automatic test_errors();
      for (int e = 0; e < 5; e++) begin
         do_reset();
         case (e)
            0: begin cq.push_back(8'd1); cq.push_back(8'd0); end
            1: begin cq.push_back(8'd1); cq.push_back(8'd3); cq.push_back(8'd3); end
            2: begin for (int b = 0; b < 5; b++) cq.push_back(8'd0); cq.push_back(8'hBA); end
            3: cq.push_back(8'd5);
            default: begin cq.push_back(8'd1); cq.push_back(8'd2); cq.push_back(8'd0); cq.push_back(8'd8); end
         endcase
         send_bytes();
         @(negedge CLK);
         tests_run++;
         if (err_conf !== 1'b1 || conf_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL err%0d: err_conf=%b conf_full=%b want 1/1", e, err_conf, conf_full);
         end
         for (int b = 0; b < 5; b++) cq.push_back(8'd0);
         cq.push_back(8'hBB);
         send_bytes();
         @(negedge CLK);
         tests_run++;
         if (err_conf !== 1'b1) begin
            tests_failed++;
            $display("FAIL err%0d_sticky: err_conf=%b want 1", e, err_conf);
         end
      end
      do_reset();
      @(negedge CLK);
      tests_run++;
      if (err_conf !== 1'b0 || conf_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_clear: err_conf=%b conf_full=%b want 0/0", err_conf, conf_full);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_two_ranges(1, 0);
      send_conf(8'hBB);
      repeat (3) @(posedge CLK);
      model_word({8{8'h2E}}, 1'b0);
      #1 word_in = {8{8'h2E}}; word_id = 16'h0A0A; word_list_end = 1'b0; word_wr_en = 1'b1;
      @(posedge CLK);
      #1 word_wr_en = 1'b0;
      @(negedge CLK);
      tests_run++;
      if (word_full !== 1'b1 || empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL accept_k: word_full=%b empty=%b want 1/1", word_full, empty);
      end
      @(negedge CLK);
      tests_run++;
      if (empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL accept_k1: empty=%b want 0", empty);
      end
      @(posedge CLK); #1 word_in = {8{8'h55}}; word_id = 16'hBAD0; word_wr_en = 1'b1;
      @(posedge CLK); #1 word_wr_en = 1'b0;
      drain(40, 16'h0A0A, "b2b_w0");
      repeat (5) @(negedge CLK);
      tests_run++;
      if (empty !== 1'b1 || word_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_ignored: empty=%b word_full=%b want 1/0", empty, word_full);
      end
      model_word({8{8'h2F}}, 1'b1);
      push_word({8{8'h2F}}, 16'h0A0B, 1'b1);
      drain(60, 16'h0A0B, "b2b_w1");
   endtask

   task automatic test_reset_mid_gen();
      int n = 0;
      bit seen;
      do_reset();
      set_two_ranges(0, 0);
      send_conf(8'hBB);
      push_word({8{8'h2D}}, 16'h0707, 1'b1);
      while (empty === 1'b1 && n < 20) begin @(negedge CLK); n++; end
      @(posedge CLK); #1 rd_en = 1'b1;
      @(posedge CLK);
      @(posedge CLK); #1 rd_en = 1'b0;
      @(negedge CLK);
      tests_run++;
      if (gen_id !== 32'd2) begin
         tests_failed++;
         $display("FAIL mid_gen_id: got %0d want 2", gen_id);
      end
      #2 RST = 1'b1;
      #1;
      tests_run++;
      if (empty !== 1'b1 || word_full !== 1'b0 || gen_id !== 32'd0 || word_id_out !== 16'd0 ||
          conf_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_rst: empty=%b full=%b gen_id=%0d id=%h conf_full=%b want 1/0/0/0/0",
                  empty, word_full, gen_id, word_id_out, conf_full);
      end
      @(posedge CLK); #1 RST = 1'b0;
      push_word({8{8'h3D}}, 16'h0808, 1'b1);
      seen = 1'b0;
      rd_en = 1'b1;
      repeat (10) begin @(negedge CLK); if (empty !== 1'b1) seen = 1'b1; end
      rd_en = 1'b0;
      tests_run++;
      if (seen) begin
         tests_failed++;
         $display("FAIL mid_noconf: output seen without configuration, want none");
      end
      send_conf(8'hBB);
      model_word({8{8'h3D}}, 1'b1);
      drain(100, 16'h0808, "mid_held");
   endtask

   task automatic test_random();
      logic [WW-1:0] w;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         nr = $urandom_range(RM);
         for (int r = 0; r < RM; r++) begin
            nc[r] = $urandom_range(4, 1);
            st[r] = $urandom_range(nc[r] - 1);
            ps[r] = $urandom_range(7);
            for (int c = 0; c < 4; c++) chs[r][c] = 8'($urandom_range(8'h7A, 8'h41));
         end
         ngen = ($urandom_range(2) == 0) ? 0 : $urandom_range(12, 1);
         send_conf(8'hBB);
         for (int i = 0; i < 3; i++) begin
            w = {$urandom, $urandom};
            model_word(w, i == 2);
            push_word(w, 16'(it * 16 + i), i == 2);
            drain($urandom_range(100, 30), 16'(it * 16 + i), "random");
         end
         tests_run++;
         if (conf_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL random_conf_full: got %b want 0", conf_full);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_two_ranges();
      test_limit();
      test_errors();
      test_back_to_back();
      test_reset_mid_gen();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
